gf180mcu_fd_sc_mcu9t5v0__cell2_bist: RTL and testbench
======================================================

// Module: gf180mcu_fd_sc_mcu9t5v0__cell2_bist
// PURPOSE
//  Built-in self-test driver/checker for 2-input combinational cells (and2 family by default).
//  Drives A1/A2 into a cell under test, waits a settle window, samples Z and compares it to a
//  truth table. It repeats a Gray-ordered sweep PASSES times.
//  Sits beside library cells in silicon test structures; start/done handshake toward test control.
// PARAMETERS
//  FUNC          4'b1000  expected Z truth table, indexed by {A2,A1} (and2=1000, or2=1110, xor2=0110)
//  SETTLE_CYCLES 2        idle cycles between driving inputs and sampling Z (0 allowed)
//  PASSES        4        full 4-vector sweeps per run (>=1)
//  ERR_W         8        width of saturating error counter
// PORTS
//  CLK       input   1      clock, rising-edge
//  RN        input   1      asynchronous active-low reset
//  start     input   1      run request, sampled only in IDLE
//  abort     input   1      synchronous run cancel
//  Z         input   1      output of cell under test
//  A1        output  1      drive to cell input A1 (registered)
//  A2        output  1      drive to cell input A2 (registered)
//  busy      output  1      run in progress
//  done      output  1      run completed; held until next accepted start
//  pass      output  1      done && err_cnt==0
//  err_cnt   output  ERR_W  mismatch count, saturates at all-ones
//  fail_vec  output  2      {A2,A1} of first mismatch
//  fail_vld  output  1      fail_vec holds a captured value
// BEHAVIOUR
//  - Reset (RN low, async): state IDLE; every output 0; counters 0.
//  - States: IDLE -> DRIVE -> SETTLE -> SAMPLE -> (DRIVE | DONE); DONE -> DRIVE on start.
//  - IDLE/DONE + start=1 at edge t: clear err_cnt, fail_vld, done and pass; vector idx=0, pass cnt=0.
//    Enter DRIVE; busy=1 from t+1.
//  - Gray sweep order {A2,A1}: 00,01,11,10; one input toggles per step.
//  - DRIVE: A1/A2 take the current vector; 1 cycle.
//  - SETTLE: SETTLE_CYCLES cycles; skipped when 0.
//  - SAMPLE: 1 cycle. Compare Z against FUNC[{A2,A1}]. On mismatch, err_cnt+1 with saturation.
//    On the first mismatch of the run, capture fail_vec and set fail_vld.
//  - After SAMPLE: advance the vector. After vector 10, wrap to 00 and increment the pass count.
//    When the pass count reaches PASSES, go to DONE.
//  - Cycles per vector = SETTLE_CYCLES+2.
//    Run length (busy high) = PASSES*4*(SETTLE_CYCLES+2); 64 with defaults.
//  - DONE: busy=0, done=1, pass=(err_cnt==0); A1/A2 return to 0.
//    err_cnt and fail_vec are held until the next start.
//  - start while busy: ignored.
//  - abort while busy: next state IDLE. busy=0, done=0, pass=0, A1=A2=0.
//    err_cnt and fail_vec keep their partial values.
//  - abort and start in the same cycle in IDLE/DONE: abort wins, no run starts.
//  - abort in IDLE/DONE: IDLE, done and pass cleared.
//  - RN asserted mid-run: immediate full reset as above; no done.
//  - Z is assumed settled at SAMPLE. No synchronizer; SETTLE_CYCLES covers the cell delay.
// STRUCTURE
//  - Package gf180mcu_fd_sc_mcu9t5v0__bist_pkg holds:
//    - state enum {IDLE,DRIVE,SETTLE,SAMPLE,DONE};
//    - Gray sequence constant;
//    - truth-table constants AND2_TT, OR2_TT, XOR2_TT.
//  - Sub-module gf180mcu_fd_sc_mcu9t5v0__bist_seq: Gray vector index, pass counter and last-vector
//    flag. Its inputs are adv and clr.
//  - Top level holds the FSM, settle counter, compare logic, error/capture registers and outputs.
// TESTING
//  1. RN low with CLK running -> all outputs 0; release RN with no start -> still idle, A1=A2=0.
//  2. Ideal and2 (Z=A1&A2), start pulse -> A sequence 00,01,11,10 x4.
//     done=1 after 64 busy cycles; pass=1, err_cnt=0, fail_vld=0.
//  3. Z stuck-at-0 -> err_cnt=4, fail_vec=2'b11, fail_vld=1, pass=0.
//  4. Z stuck-at-1 -> err_cnt=12, fail_vec=2'b00.
//     ERR_W=3 rerun -> err_cnt saturates at 7.
//  5. abort at busy cycle 20 -> IDLE next cycle, busy=0, done=0, A1=A2=0.
//     A new start then runs a clean 64-cycle pass.
//  6. RN pulsed low at busy cycle 30 -> outputs 0 immediately (async).
//     start during busy ignored. SETTLE_CYCLES=0, PASSES=1 -> 8-cycle run.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__bist_pkg.sv
// Shared types and constants for the 2-input cell BIST: FSM states, the Gray
// sweep order and truth tables of the supported cell families.
package gf180mcu_fd_sc_mcu9t5v0__bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  // Packed {A2,A1} sweep, entry 0 in the low bits: 00, 01, 11, 10
  localparam logic [7:0] GRAY_SEQ = 8'b10_11_01_00;

  localparam logic [3:0] AND2_TT = 4'b1000;
  localparam logic [3:0] OR2_TT  = 4'b1110;
  localparam logic [3:0] XOR2_TT = 4'b0110;

  function automatic logic [1:0] gray_vec(input logic [1:0] idx);
    return GRAY_SEQ[{idx, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__bist_seq.sv
// Sweep sequencer: walks the Gray vector index, counts completed passes and
// flags the final vector of the final pass.
module gf180mcu_fd_sc_mcu9t5v0__bist_seq
  import gf180mcu_fd_sc_mcu9t5v0__bist_pkg::*;
#(
  parameter int PASSES = 4
) (
  input  logic       CLK,
  input  logic       RN,
  input  logic       clr,
  input  logic       adv,
  output logic [1:0] vec,
  output logic       last
);

  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;

  logic [1:0]    idx;
  logic [PW-1:0] pass_cnt;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      idx      <= 2'd0;
      pass_cnt <= '0;
    end else if (clr) begin
      idx      <= 2'd0;
      pass_cnt <= '0;
    end else if (adv) begin
      idx <= idx + 2'd1;
      if (idx == 2'd3) begin
        pass_cnt <= pass_cnt + PW'(1);
      end
    end
  end

  assign vec  = gray_vec(idx);
  assign last = (idx == 2'd3) && (pass_cnt == PW'(PASSES - 1));

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__cell2_bist.sv
// BIST driver/checker for a 2-input combinational cell: sweeps A1/A2 in Gray
// order, samples Z after a settle window and tallies truth-table mismatches.
module gf180mcu_fd_sc_mcu9t5v0__cell2_bist
  import gf180mcu_fd_sc_mcu9t5v0__bist_pkg::*;
#(
  parameter logic [3:0] FUNC          = AND2_TT,
  parameter int         SETTLE_CYCLES = 2,
  parameter int         PASSES        = 4,
  parameter int         ERR_W         = 8
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             start,
  input  logic             abort,
  input  logic             Z,
  output logic             A1,
  output logic             A2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       fail_vec,
  output logic             fail_vld
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t        state;
  logic [SW-1:0] settle_cnt;
  logic [1:0]    vec;
  logic          last;
  logic          seq_clr;
  logic          seq_adv;
  logic          mismatch;

  assign seq_clr  = start && !abort && ((state == IDLE) || (state == DONE));
  assign seq_adv  = (state == SAMPLE) && !abort;
  assign mismatch = (Z != FUNC[{A2, A1}]);

  gf180mcu_fd_sc_mcu9t5v0__bist_seq #(
    .PASSES(PASSES)
  ) u_seq (
    .CLK (CLK),
    .RN  (RN),
    .clr (seq_clr),
    .adv (seq_adv),
    .vec (vec),
    .last(last)
  );

  // Abort has priority over everything, including a start in IDLE/DONE;
  // it keeps err_cnt/fail_vec so a cancelled run can still be inspected.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state      <= IDLE;
      settle_cnt <= '0;
      A1         <= 1'b0;
      A2         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      fail_vec   <= 2'b00;
      fail_vld   <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
      A1    <= 1'b0;
      A2    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= DRIVE;
            busy     <= 1'b1;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
            fail_vec <= 2'b00;
            fail_vld <= 1'b0;
          end
        end
        DRIVE: begin
          {A2, A1}   <= vec;
          settle_cnt <= '0;
          state      <= (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
        end
        SETTLE: begin
          if (int'(settle_cnt) >= SETTLE_CYCLES - 1) begin
            state <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        SAMPLE: begin
          if (mismatch) begin
            if (err_cnt != {ERR_W{1'b1}}) begin
              err_cnt <= err_cnt + ERR_W'(1);
            end
            if (!fail_vld) begin
              fail_vec <= {A2, A1};
              fail_vld <= 1'b1;
            end
          end
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_cnt == '0) && !mismatch;
            A1    <= 1'b0;
            A2    <= 1'b0;
          end else begin
            state <= DRIVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__cell2_bist.sv
// Self-checking bench for the 2-input cell BIST: three parameterisations, a
// modelled cell on Z (ideal, stuck-at, random faults) and a cycle-level model.
module tb_gf180mcu_fd_sc_mcu9t5v0__cell2_bist;

  logic       CLK;
  logic       RN;
  logic [2:0] start_v;
  logic [2:0] abort_v;
  logic       z;
  logic       noise;
  int         z_mode;
  int         sel;

  logic [2:0] a1_v, a2_v, busy_v, done_v, pass_v, fvld_v;
  logic [1:0] fv0, fv1, fv2;
  logic [7:0] err0, err2;
  logic [2:0] err1;

  logic       obs_a1, obs_a2, obs_busy, obs_done, obs_pass, obs_fvld;
  logic [1:0] obs_fv;
  logic [7:0] obs_err;

  int checks = 0;
  int errors = 0;
  int last_err = 0;

  int s_tab[3]   = '{2, 2, 0};
  int p_tab[3]   = '{4, 4, 1};
  int w_tab[3]   = '{8, 3, 8};
  int gray_tb[4] = '{0, 1, 3, 2};

  gf180mcu_fd_sc_mcu9t5v0__cell2_bist dut0 (
    .CLK(CLK), .RN(RN), .start(start_v[0]), .abort(abort_v[0]), .Z(z),
    .A1(a1_v[0]), .A2(a2_v[0]), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .err_cnt(err0), .fail_vec(fv0), .fail_vld(fvld_v[0])
  );

  gf180mcu_fd_sc_mcu9t5v0__cell2_bist #(.ERR_W(3)) dut1 (
    .CLK(CLK), .RN(RN), .start(start_v[1]), .abort(abort_v[1]), .Z(z),
    .A1(a1_v[1]), .A2(a2_v[1]), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .err_cnt(err1), .fail_vec(fv1), .fail_vld(fvld_v[1])
  );

  gf180mcu_fd_sc_mcu9t5v0__cell2_bist #(.SETTLE_CYCLES(0), .PASSES(1)) dut2 (
    .CLK(CLK), .RN(RN), .start(start_v[2]), .abort(abort_v[2]), .Z(z),
    .A1(a1_v[2]), .A2(a2_v[2]), .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
    .err_cnt(err2), .fail_vec(fv2), .fail_vld(fvld_v[2])
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Observation mux onto the instance currently under test
  always_comb begin
    obs_a1   = a1_v[0];
    obs_a2   = a2_v[0];
    obs_busy = busy_v[0];
    obs_done = done_v[0];
    obs_pass = pass_v[0];
    obs_fvld = fvld_v[0];
    obs_fv   = fv0;
    obs_err  = err0;
    if (sel == 1) begin
      obs_a1 = a1_v[1]; obs_a2 = a2_v[1]; obs_busy = busy_v[1]; obs_done = done_v[1];
      obs_pass = pass_v[1]; obs_fvld = fvld_v[1]; obs_fv = fv1; obs_err = {5'd0, err1};
    end else if (sel == 2) begin
      obs_a1 = a1_v[2]; obs_a2 = a2_v[2]; obs_busy = busy_v[2]; obs_done = done_v[2];
      obs_pass = pass_v[2]; obs_fvld = fvld_v[2]; obs_fv = fv2; obs_err = err2;
    end
  end

  // Cell under test: an and2 that is ideal, stuck, or randomly faulty
  always_comb begin
    case (z_mode)
      0:       z = obs_a1 & obs_a2;
      1:       z = 1'b0;
      2:       z = 1'b1;
      default: z = (obs_a1 & obs_a2) ^ noise;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input bit st, input bit ab);
    start_v = st ? (3'b001 << sel) : 3'b000;
    abort_v = ab ? (3'b001 << sel) : 3'b000;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_busy"}, 32'(obs_busy), 0);
    checkOutput({tag, "_done"}, 32'(obs_done), 0);
    checkOutput({tag, "_pass"}, 32'(obs_pass), 0);
    checkOutput({tag, "_a"}, 32'({obs_a2, obs_a1}), 0);
  endtask

  // One run on the selected instance with the behavioural model alongside.
  // Busy cycle n (1-based) sits at phase (n-1)%(S+2) of vector (n-1)/(S+2);
  // the last phase of each vector is where Z is judged.
  task automatic doRun(input int mode, input int abort_at, input int rst_at, input int glitch_at);
    int s, p, w, per, total, cnt, maxv, ph, k, ev;
    bit fvld, zc;
    logic [1:0] fv;
    s = s_tab[sel]; p = p_tab[sel]; w = w_tab[sel];
    per = s + 2; total = p * 4 * per; maxv = (1 << w) - 1;
    cnt = 0; fvld = 0; fv = 2'b00;
    z_mode = mode;
    @(negedge CLK);
    applyStimulus(1, 0);
    for (int n = 1; n <= total + 1; n++) begin
      @(negedge CLK);
      if (n <= total) begin
        ph = (n - 1) % per;
        k  = ((n - 1) / per) % 4;
        ev = gray_tb[k];
        checkOutput("busy", 32'(obs_busy), 1);
        if (ph != 0) checkOutput("vec", 32'({obs_a2, obs_a1}), 32'(ev));
        noise = 1'($urandom_range(0, 1));
        applyStimulus(n == glitch_at, n == abort_at);
        if (n == abort_at) begin
          @(negedge CLK);
          applyStimulus(0, 0);
          checkIdle("abort");
          checkOutput("abort_err", 32'(obs_err), 32'(cnt));
          checkOutput("abort_fvld", 32'(obs_fvld), 32'(fvld));
          checkOutput("abort_fv", 32'(obs_fv), 32'(fv));
          return;
        end
        if (n == rst_at) begin
          #2 RN = 1'b0;
          #1;
          checkIdle("rst");
          checkOutput("rst_err", 32'(obs_err), 0);
          checkOutput("rst_fvld", 32'(obs_fvld), 0);
          checkOutput("rst_fv", 32'(obs_fv), 0);
          @(negedge CLK);
          RN = 1'b1;
          return;
        end
        if (ph == per - 1) begin
          case (mode)
            0:       zc = (ev == 3);
            1:       zc = 1'b0;
            2:       zc = 1'b1;
            default: zc = (ev == 3) ^ noise;
          endcase
          if (zc != (ev == 3)) begin
            if (cnt < maxv) cnt++;
            if (!fvld) begin
              fvld = 1'b1;
              fv   = 2'(ev);
            end
          end
        end
      end else begin
        applyStimulus(0, 0);
        checkOutput("end_busy", 32'(obs_busy), 0);
        checkOutput("end_done", 32'(obs_done), 1);
        checkOutput("end_pass", 32'(obs_pass), 32'(cnt == 0));
        checkOutput("end_err", 32'(obs_err), 32'(cnt));
        checkOutput("end_fvld", 32'(obs_fvld), 32'(fvld));
        checkOutput("end_fv", 32'(obs_fv), 32'(fv));
        checkOutput("end_a", 32'({obs_a2, obs_a1}), 0);
        last_err = cnt;
      end
    end
  endtask

  initial begin
    RN = 1'b0; start_v = 3'b000; abort_v = 3'b000; z_mode = 0; noise = 1'b0; sel = 0;

    repeat (3) @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1;
      checkIdle("reset");
      checkOutput("reset_err", 32'(obs_err), 0);
      checkOutput("reset_fvld", 32'(obs_fvld), 0);
      checkOutput("reset_fv", 32'(obs_fv), 0);
    end
    sel = 0;
    RN = 1'b1;
    repeat (4) @(negedge CLK);
    checkIdle("post_reset");

    $display("[TB] ideal, stuck-at-0, stuck-at-1 sweeps");
    doRun(0, 0, 0, 0);
    doRun(1, 0, 0, 0);
    doRun(2, 0, 0, 0);
    sel = 1;
    doRun(2, 0, 0, 0);

    $display("[TB] abort then clean rerun");
    sel = 0;
    doRun(0, 20, 0, 0);
    doRun(0, 0, 0, 0);
    doRun(3, 22, 0, 0);

    $display("[TB] async reset mid-run, start ignored while busy");
    doRun(1, 0, 30, 0);
    repeat (2) @(negedge CLK);
    checkIdle("after_rst");
    doRun(0, 0, 0, 10);
    sel = 2;
    doRun(0, 0, 0, 3);

    $display("[TB] random cell faults");
    for (int i = 0; i < 6; i++) begin
      sel = i % 3;
      doRun(3, 0, 0, 0);
    end

    $display("[TB] abort+start together in DONE");
    sel = 0;
    doRun(2, 0, 0, 0);
    @(negedge CLK);
    applyStimulus(1, 1);
    @(negedge CLK);
    applyStimulus(0, 0);
    checkIdle("abort_start");
    checkOutput("abort_start_err", 32'(obs_err), 32'(last_err));
    repeat (2) @(negedge CLK);
    checkOutput("abort_start_idle", 32'(obs_busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
